// File: rtl/mc_mem_responder.sv
// mc_mem_responder: unified word memory for the multi-cycle CPU with programmable wait states
// Ports: clk/rst (sync, active-high); mem_rd/mem_wr request strobes; addr byte address;
// wdata write word; rdata read word (valid with ready); ready one-cycle completion pulse;
// err error flag (valid with ready); busy high from accept until the cycle after ready.
module mc_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, nextState;
  logic [31:0] mem [DEPTH];
  logic [ADDR_W-1:0] idxQ, curIdx;
  logic [31:0] wdataQ, rdataQ;
  logic [3:0] cnt;
  logic isWrQ, errQ, accept, reqErr, curWr, curErr;
  assign accept = state == IDLE && (mem_rd || mem_wr);
  assign reqErr = |addr[1:0] || |addr[31:ADDR_W+2] || (mem_rd && mem_wr);
  // With zero wait states RESP is entered straight from IDLE, so the read must
  // use the live request rather than the latched copy.
  assign curIdx = state == IDLE ? addr[ADDR_W+1:2] : idxQ;
  assign curWr  = state == IDLE ? mem_wr : isWrQ;
  assign curErr = state == IDLE ? reqErr : errQ;
  always_comb begin
    nextState = IDLE;
    nextState = state == IDLE ? (accept ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE)
              : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rdataQ <= '0;
    end else begin
      state  <= nextState;
      rdataQ <= (nextState == RESP && !curWr && !curErr) ? mem[curIdx] : '0;
      if (accept) begin
        idxQ   <= addr[ADDR_W+1:2];
        wdataQ <= wdata;
        isWrQ  <= mem_wr;
        errQ   <= reqErr;
        cnt    <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
  // Commit on the edge leaving RESP; a reset on that edge aborts the write.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && isWrQ && !errQ) mem[idxQ] <= wdataQ;
  end
  assign ready = state == RESP;
  assign err   = ready && errQ;
  assign busy  = state != IDLE;
  assign rdata = rdataQ;
endmodule

// File: tb/tb_mc_mem_responder.sv
// tb_mc_mem_responder: directed checks of mc_mem_responder with 2 and 0 wait states
module tb_mc_mem_responder;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic rd2, wr2, rd0, wr0;
  logic [31:0] a2, d2, a0, d0;
  logic [31:0] rdata2, rdata0;
  logic ready2, err2, busy2, ready0, err0, busy0;
  mc_mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .mem_rd(rd2), .mem_wr(wr2), .addr(a2), .wdata(d2),
    .rdata(rdata2), .ready(ready2), .err(err2), .busy(busy2));
  mc_mem_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_rd(rd0), .mem_wr(wr0), .addr(a0), .wdata(d0),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0));
  logic sel;
  logic sReady, sErr, sBusy;
  logic [31:0] sRdata;
  assign sReady = sel ? ready0 : ready2;
  assign sErr   = sel ? err0 : err2;
  assign sBusy  = sel ? busy0 : busy2;
  assign sRdata = sel ? rdata0 : rdata2;
  int nCmp = 0, nBad = 0;
  typedef struct {
    logic rd;
    logic wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic expErr;
    logic [31:0] expData;
  } vec_t;
  vec_t vecs[14];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      rd0 = rd; wr0 = wr; a0 = a; d0 = d;
    end else begin
      rd2 = rd; wr2 = wr; a2 = a; d2 = d;
    end
  endtask
  task automatic txn(input string nm, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic expErr, input logic [31:0] expData);
    int lat, bc, expLat;
    lat = 0;
    bc = 0;
    expLat = sel ? 1 : 3;
    @(negedge clk) drive(rd, wr, a, d);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (sBusy) bc++;
      if (sReady) begin
        lat = i;
        chk({nm, "_err"}, 32'(sErr), 32'(expErr));
        chk({nm, "_rdata"}, sRdata, expData);
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'(expLat));
    chk({nm, "_busycycles"}, 32'(bc), 32'(expLat));
    @(negedge clk);
    chk({nm, "_after_ready"}, 32'(sReady), 32'h0);
    chk({nm, "_after_busy"}, 32'(sBusy), 32'h0);
    chk({nm, "_after_rdata"}, sRdata, 32'h0);
  endtask
  task automatic waitReady2(input string nm);
    int seen;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (ready2) seen = 1;
    end
    chk({nm, "_ready_seen"}, 32'(seen), 32'h1);
  endtask
  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h12,  32'h12345678, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 1'b1, 32'h400, 32'h0000AAAA, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h400, 32'h0,        1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 32'h10,  32'h0,        1'b1, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 1'b1, 32'h3FC, 32'h01020304, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'h01020304};
    vecs[10] = '{1'b0, 1'b1, 32'h0,   32'h0BADF00D, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0BADF00D};
    vecs[12] = '{1'b0, 1'b1, 32'h24,  32'h24242424, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 32'h30,  32'h00000077, 1'b0, 32'h0};
    sel = 1'b0;
    rst = 1'b1;
    rd2 = 1'b1; wr2 = 1'b0; a2 = 32'h10; d2 = 32'h0;
    rd0 = 1'b0; wr0 = 1'b0; a0 = 32'h0;  d0 = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_ready", 32'(ready2), 32'h0);
      chk("reset_busy", 32'(busy2), 32'h0);
      chk("reset_err", 32'(err2), 32'h0);
      chk("reset_rdata", rdata2, 32'h0);
    end
    rst = 1'b0;
    rd2 = 1'b0;
    for (int i = 0; i < 14; i++)
      txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
          vecs[i].expErr, vecs[i].expData);
    txn("wrap_check", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    @(negedge clk) begin wr2 = 1'b1; a2 = 32'h20; d2 = 32'h11111111; end
    @(posedge clk);
    @(negedge clk) begin wr2 = 1'b0; a2 = 32'h24; d2 = 32'h22222222; end
    waitReady2("holdoff");
    @(negedge clk);
    txn("holdoff_rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11111111);
    txn("holdoff_rd24", 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h24242424);
    @(negedge clk) begin wr2 = 1'b1; a2 = 32'h30; d2 = 32'h55; end
    @(posedge clk);
    @(negedge clk) begin wr2 = 1'b0; rst = 1'b1; end
    @(negedge clk);
    chk("rstwait_ready", 32'(ready2), 32'h0);
    chk("rstwait_busy", 32'(busy2), 32'h0);
    chk("rstwait_err", 32'(err2), 32'h0);
    rst = 1'b0;
    txn("rstwait_rd30", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h00000077);
    @(negedge clk) begin wr2 = 1'b1; a2 = 32'h30; d2 = 32'h66; end
    @(posedge clk);
    #1 wr2 = 1'b0;
    waitReady2("rstresp");
    rst = 1'b1;
    @(negedge clk);
    chk("rstresp_busy", 32'(busy2), 32'h0);
    rst = 1'b0;
    txn("rstresp_rd30", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h00000077);
    sel = 1'b1;
    txn("zw_wr", 1'b0, 1'b1, 32'h0, 32'hCAFE0001, 1'b0, 32'h0);
    @(negedge clk) begin rd0 = 1'b1; a0 = 32'h0; end
    @(posedge clk);
    @(negedge clk);
    chk("zw_ready1", 32'(ready0), 32'h1);
    chk("zw_rdata1", rdata0, 32'hCAFE0001);
    chk("zw_busy1", 32'(busy0), 32'h1);
    @(negedge clk);
    chk("zw_idle_ready", 32'(ready0), 32'h0);
    chk("zw_idle_busy", 32'(busy0), 32'h0);
    @(negedge clk);
    chk("zw_ready2", 32'(ready0), 32'h1);
    chk("zw_rdata2", rdata0, 32'hCAFE0001);
    chk("zw_err2", 32'(err0), 32'h0);
    rd0 = 1'b0;
    @(negedge clk);
    chk("zw_end_ready", 32'(ready0), 32'h0);
    chk("zw_end_busy", 32'(busy0), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/mc_mem_responder.md
Name: mc_mem_responder

Overview:
- Unified instruction/data memory responder for the multi-cycle CPU.
- Sits on the far side of the memory control lines driven by the control unit: MemRd/MemWr, with the address already selected by IorD.
- Accepts one word read or write at a time and inserts a programmable number of wait states.
- Signals completion with a one-cycle ready pulse; the CPU sequencer holds its current state until that pulse arrives.

Parameters:
- DEPTH, 256: number of 32-bit words; must be a power of two, at least 4.
- ADDR_W, 8: word-index width, equal to log2(DEPTH).
- WAIT_CYCLES, 2: wait states inserted between accept and response; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_rd  in  1  read request (MemRd).
- mem_wr  in  1  write request (MemWr).
- addr  in  32  byte address (PC or ALUOut after the IorD mux).
- wdata  in  32  write data (register B).
- rdata  out  32  read data; valid only in the cycle ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  error flag; valid only in the cycle ready=1.
- busy  out  1  high from the accept edge until the cycle after ready.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; ready=0; err=0; busy=0; rdata=0; wait counter=0.
  - Memory array contents are not cleared.
  - Reset during WAIT or RESP aborts the transaction. An aborted write never modifies the array.
- States: IDLE, WAIT, RESP.
- IDLE:
  - A request is accepted on a clock edge when mem_rd|mem_wr=1.
  - At accept, latch addr, wdata and op (read/write); set cnt=WAIT_CYCLES and busy=1.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
  - Any change to the inputs after accept is ignored.
- WAIT: cnt decrements by 1 each cycle; move to RESP on the edge where cnt==1.
- RESP (exactly one cycle): ready=1. Next state IDLE; busy drops on that edge.
- Latency: accept at edge t gives ready=1 in cycle t+WAIT_CYCLES+1.
  - Example: WAIT_CYCLES=0 gives ready in the cycle right after accept.
- Back-to-back requests: there is a minimum of one IDLE cycle between ready and the next accept. A request held high through the IDLE cycle after ready is treated as a new request; the requester deasserts once it sees ready.
- Read: rdata = mem[addr[ADDR_W+1:2]] captured on entry to RESP. rdata returns to 0 in the cycle after RESP.
- Write: mem[index] <= wdata on the edge leaving RESP. Read data during RESP is 0.
- Error conditions, each evaluated on the latched request:
  - addr[1:0]!=0 (misaligned).
  - addr[31:ADDR_W+2]!=0 (out of range).
  - mem_rd and mem_wr both high at accept.
- Error response:
  - Full latency is still honoured; ready=1, err=1, rdata=0.
  - No array write occurs.
- Word index wraps naturally within ADDR_W bits. Only in-range addresses can reach the array.
- No byte enables; all accesses are full 32-bit words.

Test Plan:
- Write/read, WAIT_CYCLES=2:
  - Write addr=0x10, wdata=0xDEADBEEF accepted at edge t → ready=1 in cycle t+3, err=0.
  - Then read addr=0x10 → ready in cycle t'+3 with rdata=0xDEADBEEF.
  - busy stays high for 3 cycles.
- Zero wait, WAIT_CYCLES=0:
  - Read of 0x0 accepted at t → ready=1 in cycle t+1.
  - With mem_rd held high, second accept at t+2 and ready in cycle t+3.
- Errors:
  - Write addr=0x12 → ready, err=1, rdata=0; a following read of 0x10 returns the old value.
  - Write addr=0x400 (DEPTH=256) → err=1.
  - mem_rd=mem_wr=1 → err=1.
- Input hold-off: change addr and wdata one cycle after accepting a write to 0x20 with wdata=0x11111111 → word 0x20 holds 0x11111111; the new address is untouched.
- Reset mid-write: assert rst during WAIT of a write to 0x30 with wdata=0x55 →
  - next cycle ready=0, busy=0, state IDLE.
  - A later read of 0x30 returns the pre-reset value.
- Reset values: hold rst for 2 cycles → rdata=0, ready=0, err=0, busy=0. With rst=1, no request is accepted even if mem_rd=1.
